sevenseg_scan: RTL and testbench

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

---
 rtl/sevenseg_scan.sv | 111 +++++++++++
 tb/tb_sevenseg_scan.sv | 116 +++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed hex seven-segment driver with a shadow/active register pair.
// Ports: clk, rst (async, active-high); load captures value/dp_in/blank_in into the shadow
// registers; ready is high when no shadow update is pending; segs is active-low {dp,g..a};
// an is the one-hot digit enable (polarity from AN_ACTIVE_LOW); frame_tick pulses once per frame.
// Define SEVENSEG_LZB_EN to blank leading zeros of the active value.
module sevenseg_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic                    ready,
  output logic [7:0]              segs,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic started_q, started_d, ready_q, ready_d, tick_q, tick_d;
  logic [7:0] segs_q, segs_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0] blank_eff;
  logic slot_end, frame_wrap, commit;
  logic [3:0] nib;
`ifdef SEVENSEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzb;
  logic lead;
  // Walk down from the top digit; a digit stays blank while all digits above it were blank too.
  always_comb begin
    lzb = '0;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead = lead && act_val_q[4*i +: 4] == 4'h0 && !act_dp_q[i];
      lzb[i] = lead;
    end
  end
  assign blank_eff = act_blank_q | lzb;
`else
  assign blank_eff = act_blank_q;
`endif
  always_comb begin
    slot_end   = presc_q == PW'(SCAN_DIV - 1);
    // The first slot end after reset only enables the anodes; scanning starts at digit 0.
    frame_wrap = slot_end && started_q && idx_q == IW'(NUM_DIGITS - 1);
    commit     = frame_wrap && !ready_q;
    presc_d    = slot_end ? '0 : presc_q + 1'b1;
    started_d  = started_q | slot_end;
    idx_d      = (slot_end && started_q) ? (frame_wrap ? '0 : idx_q + 1'b1) : idx_q;
    ready_d    = load ? 1'b0 : (commit ? 1'b1 : ready_q);
    tick_d     = frame_wrap;
    sh_val_d   = load ? value : sh_val_q;
    sh_dp_d    = load ? dp_in : sh_dp_q;
    sh_blank_d = load ? blank_in : sh_blank_q;
    act_val_d   = commit ? sh_val_q : act_val_q;
    act_dp_d    = commit ? sh_dp_q : act_dp_q;
    act_blank_d = commit ? sh_blank_q : act_blank_q;
    nib    = act_val_q[{idx_q, 2'b00} +: 4];
    segs_d = (!started_q || blank_eff[idx_q]) ? 8'hFF : {~act_dp_q[idx_q], SEG_LUT[nib]};
    an_d   = started_q ? AN_OFF ^ (NUM_DIGITS'(1) << idx_q) : AN_OFF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      started_q   <= 1'b0;
      ready_q     <= 1'b1;
      tick_q      <= 1'b0;
      segs_q      <= 8'hFF;
      an_q        <= AN_OFF;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      started_q   <= started_d;
      ready_q     <= ready_d;
      tick_q      <= tick_d;
      segs_q      <= segs_d;
      an_q        <= an_d;
      sh_val_q    <= sh_val_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
    end
  end
  assign ready      = ready_q;
  assign segs       = segs_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed bench for sevenseg_scan with NUM_DIGITS=4, SCAN_DIV=4, active-low anodes.
module tb_sevenseg_scan;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0, blank_in = '0;
  logic ready, frame_tick;
  logic [7:0] segs;
  logic [3:0] an;
  int n_tests = 0, n_fail = 0, n;
  sevenseg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .ready(ready), .segs(segs), .an(an), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic put(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp_in = d; blank_in = b; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!frame_tick && cnt < 64);
    if (!frame_tick) chk("tick_timeout", 16'd0, 16'd1);
  endtask
  // Called on the sample right after a frame wrap; checks the four slots of that frame.
  task automatic show_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    step(2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(4);
      chk($sformatf("%s_an%0d", tag, k), {12'h0, an}, {12'h0, ~(4'b0001 << k)});
      chk($sformatf("%s_seg%0d", tag, k), {8'h0, segs}, {8'h0, e[k]});
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_segs", {8'h0, segs}, 16'h00FF);
      chk("rst_an", {12'h0, an}, 16'h000F);
      chk("rst_ready", {15'h0, ready}, 16'h1);
      chk("rst_tick", {15'h0, frame_tick}, 16'h0);
    end
    rst = 1'b0;
    step(4);
    chk("an_pre_slot", {12'h0, an}, 16'h000F);
    step(1);
    chk("an_first", {12'h0, an}, 16'h000E);
    chk("dark_first", {8'h0, segs}, 16'h00FF);
    put(16'h1234, 4'b0010, 4'b0000);
    chk("load_ready", {15'h0, ready}, 16'h0);
    chk("load_dark", {8'h0, segs}, 16'h00FF);
    wait_tick(n);
    chk("commit_ready", {15'h0, ready}, 16'h1);
    show_frame("v1234", 8'h99, 8'h30, 8'hA4, 8'hF9);
    step(1);
    put(16'h00AB, 4'b0000, 4'b0000);
    put(16'h00CD, 4'b0000, 4'b0000);
    chk("lww_ready", {15'h0, ready}, 16'h0);
    wait_tick(n);
    show_frame("lww", 8'hA1, 8'hC6, 8'hC0, 8'hC0);
    step(2);
    put(16'h1111, 4'b0000, 4'b0000);
    step(14);
    put(16'h5555, 4'b0000, 4'b0000);
    chk("sim_tick", {15'h0, frame_tick}, 16'h1);
    chk("sim_ready", {15'h0, ready}, 16'h0);
    show_frame("sim1111", 8'hF9, 8'hF9, 8'hF9, 8'hF9);
    chk("sim_pending", {15'h0, ready}, 16'h0);
    wait_tick(n);
    chk("sim_ready2", {15'h0, ready}, 16'h1);
    show_frame("sim5555", 8'h92, 8'h92, 8'h92, 8'h92);
    put(16'h0070, 4'b0000, 4'b0000);
    wait_tick(n);
`ifdef SEVENSEG_LZB_EN
    show_frame("lzb", 8'hC0, 8'hF8, 8'hFF, 8'hFF);
`else
    show_frame("zero", 8'hC0, 8'hF8, 8'hC0, 8'hC0);
`endif
    put(16'h1234, 4'b1000, 4'b0001);
    wait_tick(n);
    show_frame("blank", 8'hFF, 8'hB0, 8'hA4, 8'h79);
    step(3);
    put(16'h8888, 4'b0000, 4'b0000);
    chk("mid_ready", {15'h0, ready}, 16'h0);
    step(2);
    rst = 1'b1;
    step(2);
    chk("mid_rst_ready", {15'h0, ready}, 16'h1);
    chk("mid_rst_segs", {8'h0, segs}, 16'h00FF);
    chk("mid_rst_an", {12'h0, an}, 16'h000F);
    rst = 1'b0;
    wait_tick(n);
    chk("tick_first", 16'(n), 16'd20);
    wait_tick(n);
    chk("tick_period", 16'(n), 16'd16);
    chk("post_rst_ready", {15'h0, ready}, 16'h1);
    show_frame("dark", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
